// File: rtl/raster_frame_scanner_pkg.sv
// rtl/raster_frame_scanner_pkg.sv - shared state encoding and colour defaults for the frame scanner
package raster_frame_scanner_pkg;

   // Scanner control states; IDLE must stay at zero so reset lands there.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } scan_state_t;

   // Number of piano key columns on the stock keyboard.
   localparam int NUMBEROFKEYBOARDINPUTS = 16;

   // Colour painted over a pressed key column.
   localparam logic [23:0] COLOURWHENKEYPRESSED = 24'hFF0000;

endpackage

// File: rtl/raster_pixel_counter.sv
// rtl/raster_pixel_counter.sv - raster-order x/y/address and key-column counters
module raster_pixel_counter
   import raster_frame_scanner_pkg::*;
#(
   parameter int H_RES     = 160,
   parameter int V_RES     = 120,
   parameter int X_W       = 8,
   parameter int Y_W       = 8,
   parameter int ADDR_W    = 15,
   parameter int KEY_PITCH = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              en,
   output logic [X_W-1:0]    x,
   output logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] addr,
   output logic [X_W-1:0]    key_col,
   output logic [X_W-1:0]    key_off,
   output logic              last
);

   logic x_end;
   logic off_end;

   assign x_end   = (32'(x) == H_RES - 1);
   assign off_end = (32'(key_off) == KEY_PITCH - 1);
   assign last    = x_end && (32'(y) == V_RES - 1);

   // Step one pixel per enable; the address simply counts so no multiply is needed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         addr    <= '0;
         key_col <= '0;
         key_off <= '0;
      end else if (clear) begin
         x       <= '0;
         y       <= '0;
         addr    <= '0;
         key_col <= '0;
         key_off <= '0;
      end else if (en) begin
         if (last) begin
            x       <= '0;
            y       <= '0;
            addr    <= '0;
            key_col <= '0;
            key_off <= '0;
         end else if (x_end) begin
            x       <= '0;
            y       <= y + Y_W'(1);
            addr    <= addr + ADDR_W'(1);
            key_col <= '0;
            key_off <= '0;
         end else begin
            x    <= x + X_W'(1);
            addr <= addr + ADDR_W'(1);
            if (off_end) begin
               key_off <= '0;
               key_col <= key_col + X_W'(1);
            end else begin
               key_off <= key_off + X_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/raster_frame_scanner.sv
// rtl/raster_frame_scanner.sv - raster-order frame scanner with ROM fetch, key highlight and pixel handshake
module raster_frame_scanner
   import raster_frame_scanner_pkg::*;
#(
   parameter int H_RES         = 160,
   parameter int V_RES         = 120,
   parameter int X_W           = 8,
   parameter int Y_W           = 8,
   parameter int ADDR_W        = 15,
   parameter int COLOUR_W      = 24,
   parameter int ROM_LATENCY   = 1,
   parameter int NUM_KEYS      = NUMBEROFKEYBOARDINPUTS,
   parameter int KEY_PITCH     = 10,
   parameter int KEY_WIDTH     = 8,
   parameter int PIANO_Y_START = 92,
   parameter logic [COLOUR_W-1:0] HIGHLIGHT_COLOUR = COLOUR_W'(COLOURWHENKEYPRESSED)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [NUM_KEYS-1:0] keyStates,
   output logic [ADDR_W-1:0]   romAddress,
   output logic                romClockEnable,
   input  logic [COLOUR_W-1:0] romData,
   output logic [X_W-1:0]      pixelX,
   output logic [Y_W-1:0]      pixelY,
   output logic [COLOUR_W-1:0] pixelColour,
   output logic                pixelValid,
   input  logic                pixelReady,
   output logic                busy,
   output logic                doneDrawing
);

   scan_state_t state, state_nxt;
   logic advance, issue, load;
   logic [X_W-1:0] cnt_x, key_col, key_off;
   logic [Y_W-1:0] cnt_y;
   logic [ADDR_W-1:0] cnt_addr;
   logic cnt_last;
   logic [NUM_KEYS-1:0] key_latch;
   logic key_hit, strip_flag;
   logic [ROM_LATENCY-1:0] pipe_v;
   logic [X_W-1:0] pipe_x [ROM_LATENCY];
   logic [Y_W-1:0] pipe_y [ROM_LATENCY];
   logic           pipe_f [ROM_LATENCY];

   // Everything downstream of the counters stalls together when the output is held.
   assign advance        = !pixelValid || pixelReady;
   assign romClockEnable = advance;
   assign romAddress     = cnt_addr;

   raster_pixel_counter #(
      .H_RES(H_RES), .V_RES(V_RES), .X_W(X_W), .Y_W(Y_W),
      .ADDR_W(ADDR_W), .KEY_PITCH(KEY_PITCH)
   ) u_counter (
      .clk(clk), .rst(reset), .clear(load), .en(issue),
      .x(cnt_x), .y(cnt_y), .addr(cnt_addr),
      .key_col(key_col), .key_off(key_off), .last(cnt_last)
   );

   // Select the latched key for the current column; columns beyond the keyboard never match.
   always_comb begin
      key_hit = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (32'(key_col) == k) key_hit = key_latch[k];
      end
   end

   assign strip_flag = (32'(cnt_y) >= PIANO_Y_START) && (32'(key_off) < KEY_WIDTH) && key_hit;

   // Keys are frozen at frame start so mid-frame presses cannot tear the image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     key_latch <= '0;
      else if (load) key_latch <= keyStates;
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state, issue control and status outputs.
   always_comb begin
      state_nxt   = state;
      load        = 1'b0;
      issue       = 1'b0;
      busy        = 1'b1;
      doneDrawing = 1'b0;
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_SCAN;
            end
         end
         ST_SCAN: begin
            issue = advance;
            if (advance && cnt_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (pipe_v == '0 && pixelValid && pixelReady) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            doneDrawing = 1'b1;
            state_nxt   = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Delay line that tracks each issued address until its ROM data arrives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pipe_v <= '0;
         for (int i = 0; i < ROM_LATENCY; i++) begin
            pipe_x[i] <= '0;
            pipe_y[i] <= '0;
            pipe_f[i] <= 1'b0;
         end
      end else if (advance) begin
         pipe_v[0] <= issue;
         pipe_x[0] <= cnt_x;
         pipe_y[0] <= cnt_y;
         pipe_f[0] <= strip_flag;
         for (int i = ROM_LATENCY - 1; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_x[i] <= pipe_x[i-1];
            pipe_y[i] <= pipe_y[i-1];
            pipe_f[i] <= pipe_f[i-1];
         end
      end
   end

   // Output register; holds its pixel until the adapter takes it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pixelValid  <= 1'b0;
         pixelX      <= '0;
         pixelY      <= '0;
         pixelColour <= '0;
      end else if (advance) begin
         pixelValid <= pipe_v[ROM_LATENCY-1];
         if (pipe_v[ROM_LATENCY-1]) begin
            pixelX      <= pipe_x[ROM_LATENCY-1];
            pixelY      <= pipe_y[ROM_LATENCY-1];
            pixelColour <= pipe_f[ROM_LATENCY-1] ? HIGHLIGHT_COLOUR : romData;
         end
      end
   end

endmodule

// File: tb/tb_raster_frame_scanner.sv
// tb/tb_raster_frame_scanner.sv - randomized frame checks against a raster-order reference model
module tb_raster_frame_scanner;

   localparam int NI = 3;

   function automatic int cfg_h(int i);  case (i) 0: return 4; 1: return 8;  default: return 1;  endcase endfunction
   function automatic int cfg_v(int i);  case (i) 0: return 3; 1: return 2;  default: return 1;  endcase endfunction
   function automatic int cfg_l(int i);  case (i) 0: return 1; 1: return 3;  default: return 2;  endcase endfunction
   function automatic int cfg_p(int i);  case (i) 0: return 3; 1: return 4;  default: return 10; endcase endfunction
   function automatic int cfg_w(int i);  case (i) 0: return 1; 1: return 2;  default: return 8;  endcase endfunction
   function automatic int cfg_ys(int i); case (i) 0: return 2; 1: return 1;  default: return 92; endcase endfunction

   logic clk = 1'b0;
   logic rst;
   logic        start [NI];
   logic [15:0] keys  [NI];
   logic        ready [NI];
   logic [14:0] raddr [NI];
   logic        rce   [NI];
   logic [23:0] rdata [NI];
   logic [7:0]  px    [NI];
   logic [7:0]  py    [NI];
   logic [23:0] pc    [NI];
   logic        pv    [NI];
   logic        busy  [NI];
   logic        done  [NI];

   logic [23:0] rom_mem [64];
   logic [23:0] rp [NI][4];

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int got_n [NI] = '{0, 0, 0};
   logic [7:0]  gx [NI][1024];
   logic [7:0]  gy [NI][1024];
   logic [23:0] gc [NI][1024];
   int gcyc [NI][1024];
   int done_n [NI] = '{0, 0, 0};
   int done_cyc [NI] = '{0, 0, 0};
   int stall_chk [NI] = '{0, 0, 0};
   int stall_err [NI] = '{0, 0, 0};
   logic hold [NI] = '{1'b0, 1'b0, 1'b0};
   logic [7:0]  hx [NI];
   logic [7:0]  hy [NI];
   logic [23:0] hc [NI];
   int fb_n, fb_done;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = cfg_l(g);
      raster_frame_scanner #(
         .H_RES(cfg_h(g)), .V_RES(cfg_v(g)), .ROM_LATENCY(L),
         .KEY_PITCH(cfg_p(g)), .KEY_WIDTH(cfg_w(g)), .PIANO_Y_START(cfg_ys(g))
      ) u_dut (
         .clk(clk), .reset(rst), .start(start[g]), .keyStates(keys[g]),
         .romAddress(raddr[g]), .romClockEnable(rce[g]), .romData(rdata[g]),
         .pixelX(px[g]), .pixelY(py[g]), .pixelColour(pc[g]), .pixelValid(pv[g]),
         .pixelReady(ready[g]), .busy(busy[g]), .doneDrawing(done[g])
      );
      assign rdata[g] = rp[g][L-1];
   end

   // Clock-enabled frame memory with per-instance read latency.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rce[i]) begin
            rp[i][0] <= rom_mem[raddr[i][5:0]];
            for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
         end
      end
   end

   // Record accepted pixels, done pulses and output stability during stalls.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < NI; i++) begin
         if (pv[i] && ready[i]) begin
            gx[i][got_n[i] & 1023]   <= px[i];
            gy[i][got_n[i] & 1023]   <= py[i];
            gc[i][got_n[i] & 1023]   <= pc[i];
            gcyc[i][got_n[i] & 1023] <= cyc;
            got_n[i] <= got_n[i] + 1;
         end
         if (done[i]) begin
            done_n[i]   <= done_n[i] + 1;
            done_cyc[i] <= cyc;
         end
         if (hold[i] && !rst) begin
            stall_chk[i] <= stall_chk[i] + 1;
            if (!pv[i] || px[i] !== hx[i] || py[i] !== hy[i] || pc[i] !== hc[i])
               stall_err[i] <= stall_err[i] + 1;
         end
         hold[i] <= pv[i] && !ready[i] && !rst;
         hx[i] <= px[i];
         hy[i] <= py[i];
         hc[i] <= pc[i];
      end
   end

   // Expected colour of raster index idx: highlight inside a pressed key column, else memory.
   function automatic logic [23:0] model_colour(int i, int idx, logic [15:0] k);
      int x, y, col;
      x   = idx % cfg_h(i);
      y   = idx / cfg_h(i);
      col = x / cfg_p(i);
      if (y >= cfg_ys(i) && (x % cfg_p(i)) < cfg_w(i) && col < 16 && k[col[3:0]]) return 24'hFF0000;
      return rom_mem[idx];
   endfunction

   task automatic fill_rom();
      for (int a = 0; a < 64; a++) rom_mem[a] = 24'($urandom);
   endtask

   // Start one frame on instance i and drive pixelReady until doneDrawing or the cycle budget.
   task automatic run_frame(input int i, input logic [15:0] k, input logic [15:0] k_mid,
                            input int mode, input int restart_at, output int lat, output int tmo);
      fb_n = got_n[i];
      fb_done = done_n[i];
      keys[i] = k;
      start[i] = 1'b1;
      ready[i] = 1'b1;
      @(posedge clk); #1;
      start[i] = 1'b0;
      lat = -1;
      tmo = 1;
      for (int n = 1; n <= 600; n++) begin
         case (mode)
            0: ready[i] = 1'b1;
            1: ready[i] = (n % 3 == 1);
            default: ready[i] = 1'($urandom_range(0, 1));
         endcase
         start[i] = (n == restart_at);
         if (n == 3) keys[i] = k_mid;
         @(posedge clk); #1;
         if (lat < 0 && pv[i]) lat = n;
         if (done_n[i] != fb_done) begin
            tmo = 0;
            break;
         end
      end
      ready[i] = 1'b1;
      start[i] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < NI; i++) begin
         vectors++;
         if ({pv[i], busy[i], done[i], px[i], py[i], pc[i], raddr[i]} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs inst%0d got v=%b b=%b d=%b x=%0d y=%0d c=%h a=%0d want all 0",
                     i, pv[i], busy[i], done[i], px[i], py[i], pc[i], raddr[i]);
         end
      end
   endtask

   task automatic test_basic();
      int lat, tmo, n;
      for (int a = 0; a < 64; a++) rom_mem[a] = 24'(a);
      run_frame(0, 16'h0, 16'h0, 0, 0, lat, tmo);
      n = got_n[0] - fb_n;
      vectors++; if (tmo !== 0) begin miscompares++; $display("FAIL basic_timeout got %0d want 0", tmo); end
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL basic_latency got %0d want 2", lat); end
      vectors++; if (n !== 12) begin miscompares++; $display("FAIL basic_count got %0d want 12", n); end
      for (int p = 0; p < 12; p++) begin
         int e;
         e = (fb_n + p) & 1023;
         vectors++;
         if (gx[0][e] !== 8'(p % 4) || gy[0][e] !== 8'(p / 4) || gc[0][e] !== 24'(p)) begin
            miscompares++;
            $display("FAIL basic_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", p, gx[0][e], gy[0][e], gc[0][e], p % 4, p / 4, p);
         end
      end
      vectors++;
      if (done_n[0] - fb_done !== 1) begin miscompares++; $display("FAIL basic_done_count got %0d want 1", done_n[0] - fb_done); end
      vectors++;
      if (done_cyc[0] - gcyc[0][(fb_n + 11) & 1023] !== 1) begin
         miscompares++;
         $display("FAIL basic_done_delay got %0d want 1", done_cyc[0] - gcyc[0][(fb_n + 11) & 1023]);
      end
   endtask

   task automatic test_backpressure();
      int lat, tmo, n, se, sc;
      fill_rom();
      se = stall_err[0];
      sc = stall_chk[0];
      run_frame(0, 16'h0, 16'h0, 1, 0, lat, tmo);
      n = got_n[0] - fb_n;
      vectors++; if (tmo !== 0 || n !== 12) begin miscompares++; $display("FAIL bp_count got %0d (timeout %0d) want 12", n, tmo); end
      for (int p = 0; p < 12; p++) begin
         int e;
         e = (fb_n + p) & 1023;
         vectors++;
         if (gx[0][e] !== 8'(p % 4) || gy[0][e] !== 8'(p / 4) || gc[0][e] !== model_colour(0, p, 16'h0)) begin
            miscompares++;
            $display("FAIL bp_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", p, gx[0][e], gy[0][e], gc[0][e], p % 4, p / 4, model_colour(0, p, 16'h0));
         end
      end
      vectors++; if (stall_err[0] !== se) begin miscompares++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err[0] - se); end
      vectors++; if (stall_chk[0] <= sc) begin miscompares++; $display("FAIL bp_stalls_seen got %0d want >0", stall_chk[0] - sc); end
      vectors++; if (done_n[0] - fb_done !== 1) begin miscompares++; $display("FAIL bp_done_count got %0d want 1", done_n[0] - fb_done); end
   endtask

   task automatic test_latency3();
      int lat, tmo, n;
      fill_rom();
      run_frame(1, 16'h0, 16'h0, 0, 0, lat, tmo);
      n = got_n[1] - fb_n;
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL lat3_latency got %0d want 4", lat); end
      vectors++; if (tmo !== 0 || n !== 16) begin miscompares++; $display("FAIL lat3_count got %0d (timeout %0d) want 16", n, tmo); end
      for (int p = 0; p < 16; p++) begin
         int e;
         e = (fb_n + p) & 1023;
         vectors++;
         if (gx[1][e] !== 8'(p % 8) || gy[1][e] !== 8'(p / 8) || gc[1][e] !== model_colour(1, p, 16'h0)) begin
            miscompares++;
            $display("FAIL lat3_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", p, gx[1][e], gy[1][e], gc[1][e], p % 8, p / 8, model_colour(1, p, 16'h0));
         end
      end
      vectors++;
      if (gcyc[1][(fb_n + 15) & 1023] - gcyc[1][fb_n & 1023] !== 15) begin
         miscompares++;
         $display("FAIL lat3_back_to_back got span %0d want 15", gcyc[1][(fb_n + 15) & 1023] - gcyc[1][fb_n & 1023]);
      end
   endtask

   task automatic test_keys();
      int lat, tmo, n;
      fill_rom();
      run_frame(1, 16'b10, 16'h0, 2, 0, lat, tmo);
      n = got_n[1] - fb_n;
      vectors++; if (tmo !== 0 || n !== 16) begin miscompares++; $display("FAIL keys_count got %0d (timeout %0d) want 16", n, tmo); end
      for (int p = 0; p < 16; p++) begin
         int e;
         e = (fb_n + p) & 1023;
         vectors++;
         if (gx[1][e] !== 8'(p % 8) || gy[1][e] !== 8'(p / 8) || gc[1][e] !== model_colour(1, p, 16'b10)) begin
            miscompares++;
            $display("FAIL keys_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", p, gx[1][e], gy[1][e], gc[1][e], p % 8, p / 8, model_colour(1, p, 16'b10));
         end
      end
   endtask

   task automatic test_random();
      int lat, tmo, n, i, nexp;
      logic [15:0] k;
      for (int f = 0; f < 6; f++) begin
         i = f % NI;
         k = 16'($urandom);
         nexp = cfg_h(i) * cfg_v(i);
         fill_rom();
         run_frame(i, k, 16'($urandom), 2, 0, lat, tmo);
         n = got_n[i] - fb_n;
         vectors++; if (tmo !== 0 || n !== nexp) begin miscompares++; $display("FAIL rand%0d_count got %0d (timeout %0d) want %0d", f, n, tmo, nexp); end
         for (int p = 0; p < nexp; p++) begin
            int e;
            e = (fb_n + p) & 1023;
            vectors++;
            if (gx[i][e] !== 8'(p % cfg_h(i)) || gy[i][e] !== 8'(p / cfg_h(i)) || gc[i][e] !== model_colour(i, p, k)) begin
               miscompares++;
               $display("FAIL rand%0d_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", f, p, gx[i][e], gy[i][e], gc[i][e],
                        p % cfg_h(i), p / cfg_h(i), model_colour(i, p, k));
            end
         end
         vectors++; if (done_n[i] - fb_done !== 1) begin miscompares++; $display("FAIL rand%0d_done got %0d want 1", f, done_n[i] - fb_done); end
      end
   endtask

   task automatic test_start_busy();
      int lat, tmo, n;
      fill_rom();
      run_frame(0, 16'h0, 16'h0, 0, 4, lat, tmo);
      n = got_n[0] - fb_n;
      vectors++; if (tmo !== 0 || n !== 12) begin miscompares++; $display("FAIL restart_count got %0d (timeout %0d) want 12", n, tmo); end
      vectors++; if (done_n[0] - fb_done !== 1) begin miscompares++; $display("FAIL restart_done got %0d want 1", done_n[0] - fb_done); end
      vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL restart_idle busy got %b want 0", busy[0]); end
   endtask

   task automatic test_reset_abort();
      int lat, tmo, n, d0;
      fill_rom();
      keys[0] = 16'h0;
      start[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      d0 = done_n[0];
      rst = 1'b1;
      #1;
      vectors++; if (pv[0] !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", pv[0]); end
      vectors++; if (busy[0] !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", busy[0]); end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      vectors++; if (done_n[0] !== d0) begin miscompares++; $display("FAIL abort_no_done got %0d pulses want 0", done_n[0] - d0); end
      run_frame(0, 16'h0, 16'h0, 0, 0, lat, tmo);
      n = got_n[0] - fb_n;
      vectors++; if (tmo !== 0 || n !== 12) begin miscompares++; $display("FAIL abort_refr_count got %0d (timeout %0d) want 12", n, tmo); end
      for (int p = 0; p < 12; p++) begin
         int e;
         e = (fb_n + p) & 1023;
         vectors++;
         if (gx[0][e] !== 8'(p % 4) || gy[0][e] !== 8'(p / 4) || gc[0][e] !== model_colour(0, p, 16'h0)) begin
            miscompares++;
            $display("FAIL abort_pix%0d got (%0d,%0d,%h) want (%0d,%0d,%h)", p, gx[0][e], gy[0][e], gc[0][e], p % 4, p / 4, model_colour(0, p, 16'h0));
         end
      end
   endtask

   task automatic test_one_pixel();
      int lat, tmo, n;
      fill_rom();
      run_frame(2, 16'h0, 16'h0, 0, 0, lat, tmo);
      n = got_n[2] - fb_n;
      vectors++; if (tmo !== 0 || n !== 1) begin miscompares++; $display("FAIL one_count got %0d (timeout %0d) want 1", n, tmo); end
      vectors++;
      if (gx[2][fb_n & 1023] !== 8'd0 || gy[2][fb_n & 1023] !== 8'd0 || gc[2][fb_n & 1023] !== rom_mem[0]) begin
         miscompares++;
         $display("FAIL one_pix got (%0d,%0d,%h) want (0,0,%h)", gx[2][fb_n & 1023], gy[2][fb_n & 1023], gc[2][fb_n & 1023], rom_mem[0]);
      end
      vectors++; if (lat !== 3) begin miscompares++; $display("FAIL one_latency got %0d want 3", lat); end
      vectors++; if (done_n[2] - fb_done !== 1) begin miscompares++; $display("FAIL one_done got %0d want 1", done_n[2] - fb_done); end
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         start[i] = 1'b0;
         keys[i]  = 16'h0;
         ready[i] = 1'b1;
      end
      for (int a = 0; a < 64; a++) rom_mem[a] = 24'(a);
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_basic();
      test_backpressure();
      test_latency3();
      test_keys();
      test_start_busy();
      test_reset_abort();
      test_one_pixel();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d want finish earlier", cyc);
      $fatal(1);
   end

endmodule
